// File: rtl/pipe_ctrl_if.sv
// Hazard/sequencing bus between the RV32I pipeline datapath and pipe_ctrl.
// PIPE_CTRL_PERF_CNT_EN adds the stall/flush performance counters.
interface pipe_ctrl_if;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic [4:0]  ex_rd_addr_i;
  logic        ex_mem_re_i;
  logic        ex_jump_en_i;
  logic [31:0] ex_jump_addr_i;
  logic        mem_req_i;
  logic        dmem_ready_i;
  logic        pc_stall_o;
  logic        if_id_stall_o;
  logic        id_ex_stall_o;
  logic        ex_mem_stall_o;
  logic        if_id_flush_o;
  logic        id_ex_flush_o;
  logic        mem_wb_flush_o;
  logic        pc_load_o;
  logic [31:0] pc_target_o;
  logic        mem_err_o;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  modport master (
    output id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i, ex_mem_re_i,
           ex_jump_en_i, ex_jump_addr_i, mem_req_i, dmem_ready_i,
    input  pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
           if_id_flush_o, id_ex_flush_o, mem_wb_flush_o,
           pc_load_o, pc_target_o, mem_err_o
`ifdef PIPE_CTRL_PERF_CNT_EN
    , input stall_cnt_o, flush_cnt_o
`endif
  );

  modport slave (
    input  id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i, ex_mem_re_i,
           ex_jump_en_i, ex_jump_addr_i, mem_req_i, dmem_ready_i,
    output pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
           if_id_flush_o, id_ex_flush_o, mem_wb_flush_o,
           pc_load_o, pc_target_o, mem_err_o
`ifdef PIPE_CTRL_PERF_CNT_EN
    , output stall_cnt_o, flush_cnt_o
`endif
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// PIPE_CTRL_PERF_CNT_EN enables stall/flush performance counters.
//
// state    | meaning
// RUN      | normal flow; redirect and load-use handling active
// MEM_WAIT | data memory access outstanding, pipeline frozen
// HALT     | memory timeout; frozen until reset
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input logic      clk,
  input logic      rst,
  pipe_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic              mem_err, mem_err_nxt;
  logic              pend_jump, pend_jump_nxt;
  logic [31:0]       pend_addr, pend_addr_nxt;
  logic              load_use;
  logic              mem_stall;

  assign load_use = bus.ex_mem_re_i && (bus.ex_rd_addr_i != 5'd0) &&
                    (((bus.id_rs1_addr_i != 5'd0) && (bus.id_rs1_addr_i == bus.ex_rd_addr_i)) ||
                     ((bus.id_rs2_addr_i != 5'd0) && (bus.id_rs2_addr_i == bus.ex_rd_addr_i)));

  // In MEM_WAIT the access is known outstanding, so only ready matters.
  assign mem_stall = (state == MEM_WAIT) ? !bus.dmem_ready_i
                                         : (bus.mem_req_i && !bus.dmem_ready_i);

  assign bus.mem_err_o = mem_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      pend_jump <= 1'b0;
      pend_addr <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mem_err   <= mem_err_nxt;
      pend_jump <= pend_jump_nxt;
      pend_addr <= pend_addr_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    wait_cnt_nxt       = wait_cnt;
    mem_err_nxt        = mem_err;
    pend_jump_nxt      = pend_jump;
    pend_addr_nxt      = pend_addr;
    bus.pc_stall_o     = 1'b0;
    bus.if_id_stall_o  = 1'b0;
    bus.id_ex_stall_o  = 1'b0;
    bus.ex_mem_stall_o = 1'b0;
    bus.if_id_flush_o  = 1'b0;
    bus.id_ex_flush_o  = 1'b0;
    bus.mem_wb_flush_o = 1'b0;
    bus.pc_load_o      = 1'b0;
    bus.pc_target_o    = 32'd0;

    if (rst) begin
      bus.if_id_flush_o  = 1'b1;
      bus.id_ex_flush_o  = 1'b1;
      bus.mem_wb_flush_o = 1'b1;
    end else if (state == HALT) begin
      bus.pc_stall_o     = 1'b1;
      bus.if_id_stall_o  = 1'b1;
      bus.id_ex_stall_o  = 1'b1;
      bus.ex_mem_stall_o = 1'b1;
      bus.mem_wb_flush_o = 1'b1;
    end else if (mem_stall) begin
      bus.pc_stall_o     = 1'b1;
      bus.if_id_stall_o  = 1'b1;
      bus.id_ex_stall_o  = 1'b1;
      bus.ex_mem_stall_o = 1'b1;
      bus.mem_wb_flush_o = 1'b1;
      // EX is frozen, so a resolved jump is parked until the access completes.
      if (bus.ex_jump_en_i) begin
        pend_jump_nxt = 1'b1;
        pend_addr_nxt = bus.ex_jump_addr_i;
      end
      if (state == RUN) begin
        state_nxt    = MEM_WAIT;
        wait_cnt_nxt = CNT_W'(1);
      end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
        state_nxt   = HALT;
        mem_err_nxt = 1'b1;
      end else begin
        wait_cnt_nxt = wait_cnt + 1'b1;
      end
    end else begin
      state_nxt     = RUN;
      wait_cnt_nxt  = '0;
      pend_jump_nxt = 1'b0;
      if (bus.ex_jump_en_i || pend_jump) begin
        bus.pc_load_o     = 1'b1;
        bus.pc_target_o   = pend_jump ? pend_addr : bus.ex_jump_addr_i;
        bus.if_id_flush_o = 1'b1;
        bus.id_ex_flush_o = 1'b1;
      end else if (load_use) begin
        bus.pc_stall_o    = 1'b1;
        bus.if_id_stall_o = 1'b1;
        bus.id_ex_flush_o = 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.pc_stall_o) stall_cnt <= stall_cnt + 32'd1;
      if (bus.pc_load_o)  flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt_o = stall_cnt;
  assign bus.flush_cnt_o = flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed vector bench for pipe_ctrl with MEM_TIMEOUT reduced to 4.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [4:0]  rs1, rs2, rd;
    logic        re, jmp;
    logic [31:0] jaddr;
    logic        req, rdy;
    logic [3:0]  e_stall;  // {pc, if_id, id_ex, ex_mem}
    logic [2:0]  e_flush;  // {if_id, id_ex, mem_wb}
    logic        e_load;
    logic [31:0] e_tgt;
    logic        e_err;
  } vec_t;

  vec_t vq[$];
  int   nvec = 0;
  int   nerr = 0;
  int   exp_stall_cnt = 0;
  int   exp_flush_cnt = 0;

  function automatic vec_t mk(string name, logic r, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic re, logic jmp, logic [31:0] jaddr,
                              logic req, logic rdy, logic [3:0] es, logic [2:0] ef,
                              logic el, logic [31:0] et, logic ee);
    vec_t v;
    v.name = name; v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.re = re; v.jmp = jmp; v.jaddr = jaddr; v.req = req; v.rdy = rdy;
    v.e_stall = es; v.e_flush = ef; v.e_load = el; v.e_tgt = et; v.e_err = ee;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic [3:0] a_stall;
    logic [2:0] a_flush;
    @(negedge clk);
    rst                = v.rst;
    bus.id_rs1_addr_i  = v.rs1;
    bus.id_rs2_addr_i  = v.rs2;
    bus.ex_rd_addr_i   = v.rd;
    bus.ex_mem_re_i    = v.re;
    bus.ex_jump_en_i   = v.jmp;
    bus.ex_jump_addr_i = v.jaddr;
    bus.mem_req_i      = v.req;
    bus.dmem_ready_i   = v.rdy;
    #2;
    a_stall = {bus.pc_stall_o, bus.if_id_stall_o, bus.id_ex_stall_o, bus.ex_mem_stall_o};
    a_flush = {bus.if_id_flush_o, bus.id_ex_flush_o, bus.mem_wb_flush_o};
    nvec++;
    if (a_stall !== v.e_stall || a_flush !== v.e_flush || bus.pc_load_o !== v.e_load ||
        bus.pc_target_o !== v.e_tgt || bus.mem_err_o !== v.e_err) begin
      nerr++;
      $display("FAIL %s: got stall=%b flush=%b load=%b tgt=%h err=%b, want stall=%b flush=%b load=%b tgt=%h err=%b",
               v.name, a_stall, a_flush, bus.pc_load_o, bus.pc_target_o, bus.mem_err_o,
               v.e_stall, v.e_flush, v.e_load, v.e_tgt, v.e_err);
    end
    if (v.rst) begin
      exp_stall_cnt = 0;
      exp_flush_cnt = 0;
    end else begin
      if (v.e_stall[3]) exp_stall_cnt++;
      if (v.e_load)     exp_flush_cnt++;
    end
  endtask

  initial begin
    bus.id_rs1_addr_i  = '0;
    bus.id_rs2_addr_i  = '0;
    bus.ex_rd_addr_i   = '0;
    bus.ex_mem_re_i    = 1'b0;
    bus.ex_jump_en_i   = 1'b0;
    bus.ex_jump_addr_i = '0;
    bus.mem_req_i      = 1'b0;
    bus.dmem_ready_i   = 1'b0;
    repeat (2) @(posedge clk);

    //            name          rst rs1 rs2 rd re jmp jaddr          req rdy stall    flush   ld tgt            err
    vq.push_back(mk("reset0",    1, 0,  0,  0, 0, 0, 32'h0,          0,  0,  4'b0000, 3'b111, 0, 32'h0,          0));
    vq.push_back(mk("reset1",    1, 0,  0,  0, 0, 0, 32'h0,          0,  0,  4'b0000, 3'b111, 0, 32'h0,          0));
    vq.push_back(mk("idle",      0, 0,  0,  0, 0, 0, 32'h0,          0,  0,  4'b0000, 3'b000, 0, 32'h0,          0));
    vq.push_back(mk("lu_rs2",    0, 0,  5,  5, 1, 0, 32'h0,          0,  0,  4'b1100, 3'b010, 0, 32'h0,          0));
    vq.push_back(mk("lu_rd0",    0, 0,  0,  0, 1, 0, 32'h0,          0,  0,  4'b0000, 3'b000, 0, 32'h0,          0));
    vq.push_back(mk("lu_rs1",    0, 7,  3,  7, 1, 0, 32'h0,          0,  0,  4'b1100, 3'b010, 0, 32'h0,          0));
    vq.push_back(mk("no_load",   0, 7,  3,  7, 0, 0, 32'h0,          0,  0,  4'b0000, 3'b000, 0, 32'h0,          0));
    vq.push_back(mk("lu_nomatch",0, 4,  6,  9, 1, 0, 32'h0,          0,  0,  4'b0000, 3'b000, 0, 32'h0,          0));
    vq.push_back(mk("wait1",     0, 0,  0,  0, 0, 0, 32'h0,          1,  0,  4'b1111, 3'b001, 0, 32'h0,          0));
    vq.push_back(mk("wait2",     0, 0,  0,  0, 0, 0, 32'h0,          1,  0,  4'b1111, 3'b001, 0, 32'h0,          0));
    vq.push_back(mk("wait3",     0, 0,  0,  0, 0, 0, 32'h0,          1,  0,  4'b1111, 3'b001, 0, 32'h0,          0));
    vq.push_back(mk("wait_rdy",  0, 0,  0,  0, 0, 0, 32'h0,          1,  1,  4'b0000, 3'b000, 0, 32'h0,          0));
    vq.push_back(mk("after_wait",0, 0,  0,  0, 0, 0, 32'h0,          0,  0,  4'b0000, 3'b000, 0, 32'h0,          0));
    vq.push_back(mk("zero_wait", 0, 0,  0,  0, 0, 0, 32'h0,          1,  1,  4'b0000, 3'b000, 0, 32'h0,          0));
    vq.push_back(mk("jw_cap",    0, 0,  0,  0, 0, 1, 32'h0000_0100,  1,  0,  4'b1111, 3'b001, 0, 32'h0,          0));
    vq.push_back(mk("jw_hold",   0, 0,  0,  0, 0, 1, 32'h0000_0100,  1,  0,  4'b1111, 3'b001, 0, 32'h0,          0));
    vq.push_back(mk("jw_rdy",    0, 0,  0,  0, 0, 0, 32'h0,          1,  1,  4'b0000, 3'b110, 1, 32'h0000_0100,  0));
    vq.push_back(mk("jw_clear",  0, 0,  0,  0, 0, 0, 32'h0,          0,  0,  4'b0000, 3'b000, 0, 32'h0,          0));
    vq.push_back(mk("jmp_lu",    0, 5,  0,  5, 1, 1, 32'h0000_0080,  0,  0,  4'b0000, 3'b110, 1, 32'h0000_0080,  0));
    vq.push_back(mk("jmp_plain", 0, 0,  0,  0, 0, 1, 32'hDEAD_BEE0,  0,  0,  4'b0000, 3'b110, 1, 32'hDEAD_BEE0,  0));
    vq.push_back(mk("mw_enter",  0, 0,  0,  0, 0, 0, 32'h0,          1,  0,  4'b1111, 3'b001, 0, 32'h0,          0));
    vq.push_back(mk("mw_rst",    1, 0,  0,  0, 0, 0, 32'h0,          1,  0,  4'b0000, 3'b111, 0, 32'h0,          0));
    vq.push_back(mk("mw_run",    0, 0,  0,  0, 0, 0, 32'h0,          0,  0,  4'b0000, 3'b000, 0, 32'h0,          0));

    for (int i = 0; i < vq.size(); i++) apply(vq[i]);

    // Timeout: four stalled cycles, then HALT regardless of ready or jumps.
    for (int i = 0; i < 4; i++)
      apply(mk("to_stall", 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 4'b1111, 3'b001, 0, 32'h0, 0));
    for (int i = 0; i < 3; i++)
      apply(mk("halt", 0, 5, 0, 5, 1, 1, 32'h0000_0200, 0, 1, 4'b1111, 3'b001, 0, 32'h0, 1));
    apply(mk("halt_rst", 1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 4'b0000, 3'b111, 0, 32'h0, 1));
    apply(mk("post_rst", 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 4'b0000, 3'b000, 0, 32'h0, 0));
    apply(mk("post_lu",  0, 9, 0, 9, 1, 0, 32'h0, 0, 0, 4'b1100, 3'b010, 0, 32'h0, 0));

`ifdef PIPE_CTRL_PERF_CNT_EN
    @(negedge clk);
    nvec++;
    if (bus.stall_cnt_o !== 32'(exp_stall_cnt) || bus.flush_cnt_o !== 32'(exp_flush_cnt)) begin
      nerr++;
      $display("FAIL perf_cnt: got stall=%0d flush=%0d, want stall=%0d flush=%0d",
               bus.stall_cnt_o, bus.flush_cnt_o, exp_stall_cnt, exp_flush_cnt);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
